// File: rtl/uart_tx_ctrl_if.sv
// Bus and transmitter-side signals of the UART transmit controller.
// trmt is a one-cycle start pulse; tx_done is cleared by the transmitter on trmt and set at end of frame.
interface uart_tx_ctrl_if;
  logic       wr_en;
  logic       rd_en;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [7:0] DBL;
  logic [4:0] DBH;

  modport master (
    output wr_en, rd_en, addr, wdata, tx_done,
    input  rdata, trmt, tx_data, DBL, DBH
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata, tx_done,
    output rdata, trmt, tx_data, DBL, DBH
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Buffers bus writes in a FIFO and feeds them to the UART transmitter one frame at a time.
// Owns the baud divisor, which is only updated while no frame is in flight.
module uart_tx_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_ctrl_if.slave bus,
  output logic [1:0]    o_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CLR  = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic          r_ovf;
  logic [7:0]    r_pending_dbl;
  logic [4:0]    r_pending_dbh;
  logic [7:0]    r_dbl;
  logic [4:0]    r_dbh;
  logic [7:0]    r_rdata;
  logic [7:0]    r_tx_data;
  logic          r_trmt;

  logic       w_empty;
  logic       w_full;
  logic       w_busy;
  logic       w_push_req;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic       w_status_rd;
  logic [7:0] w_status;

  assign w_empty     = (r_count == 4'd0);
  assign w_full      = (r_count == 4'(DEPTH));
  assign w_busy      = (r_state != IDLE);
  assign w_push_req  = bus.wr_en && (bus.addr == 2'd0);
  assign w_pop       = (r_state == IDLE) && !w_empty;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && !w_push;
  assign w_status_rd = bus.rd_en && (bus.addr == 2'd1);
  assign w_status    = {r_count, r_ovf, w_busy, w_full, w_empty};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a STATUS read keeps ovf set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf         <= 1'b0;
      r_pending_dbl <= 8'hB2;
      r_pending_dbh <= 5'h01;
      r_rdata       <= 8'h00;
    end else begin
      if (w_drop)           r_ovf <= 1'b1;
      else if (w_status_rd) r_ovf <= 1'b0;
      if (bus.wr_en && bus.addr == 2'd2) r_pending_dbl <= bus.wdata;
      if (bus.wr_en && bus.addr == 2'd3) r_pending_dbh <= bus.wdata[4:0];
      if (bus.rd_en) begin
        case (bus.addr)
          2'd0:    r_rdata <= 8'h00;
          2'd1:    r_rdata <= w_status;
          2'd2:    r_rdata <= r_pending_dbl;
          default: r_rdata <= {3'b000, r_pending_dbh};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tx_data <= 8'h00;
      r_trmt    <= 1'b0;
      r_dbl     <= 8'hB2;
      r_dbh     <= 5'h01;
    end else begin
      r_trmt <= 1'b0;
      case (r_state)
        IDLE: begin
          r_dbl <= r_pending_dbl;
          r_dbh <= r_pending_dbh;
          if (!w_empty) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_trmt    <= 1'b1;
            r_state   <= LOAD;
          end
        end
        LOAD: r_state <= CLR;
        // tx_done may still hold the previous frame's flag here.
        CLR:  r_state <= WAIT;
        WAIT: if (bus.tx_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdata   = r_rdata;
  assign bus.trmt    = r_trmt;
  assign bus.tx_data = r_tx_data;
  assign bus.DBL     = r_dbl;
  assign bus.DBH     = r_dbh;
  assign o_state     = r_state;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a small transmitter model and a byte-order scoreboard.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic       tx_done_r = 1'b0;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(.DEPTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .o_state (dbg_state)
  );

  assign bus.tx_done = tx_done_r;

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  int         frame_len = 20;
  bit         tx_hold = 1'b0;
  int         frame_cnt = 0;
  int         trmt_cnt = 0;
  logic       prev_trmt = 1'b0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Transmitter model: clears done on trmt, raises it frame_len cycles later unless held.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_done_r = 1'b0;
      frame_cnt = 0;
      prev_trmt = 1'b0;
    end else begin
      if (bus.trmt) begin
        trmt_cnt++;
        check("trmt_gap", {7'b0, prev_trmt}, 8'h00);
        if (exp_q.size() == 0) check("trmt_unexp", {7'b0, bus.trmt}, 8'h00);
        else check("tx_data", bus.tx_data, exp_q.pop_front());
        tx_done_r = 1'b0;
        frame_cnt = frame_len;
      end else if (frame_cnt > 0 && !tx_hold) begin
        frame_cnt--;
        if (frame_cnt == 0) tx_done_r = 1'b1;
      end
      prev_trmt = bus.trmt;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.rdata;
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    for (int i = 0; i < 500 && dbg_state != s; i++) @(negedge clk);
    check(tag, {6'b0, dbg_state}, {6'b0, s});
  endtask

  task automatic wait_trmt(input string tag);
    for (int i = 0; i < 500 && !bus.trmt; i++) @(negedge clk);
    check(tag, {7'b0, bus.trmt}, 8'h01);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 1000 && (exp_q.size() != 0 || dbg_state != 2'd0); i++) @(negedge clk);
    check(tag, 8'(exp_q.size()), 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int         rec;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 8'h00;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_trmt", {7'b0, bus.trmt}, 8'h00);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_rdata", bus.rdata, 8'h00);
    check("rst_dbl", bus.DBL, 8'hB2);
    check("rst_dbh", {3'b0, bus.DBH}, 8'h01);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(2'd1, d); check("rst_status", d, 8'h01);
    bus_read(2'd2, d); check("rst_pend_dbl", d, 8'hB2);
    bus_read(2'd3, d); check("rst_pend_dbh", d, 8'h01);
    bus_read(2'd0, d); check("rd_txdata", d, 8'h00);

    // Single byte: trmt two cycles after the write, stale done ignored afterwards
    frame_len = 20;
    exp_q.push_back(8'hA5);
    bus_write(2'd0, 8'hA5);
    check("single_n1", {7'b0, bus.trmt}, 8'h00);
    @(negedge clk);
    check("single_trmt", {7'b0, bus.trmt}, 8'h01);
    check("single_data", bus.tx_data, 8'hA5);
    wait_state(2'd0, "single_idle");
    bus_read(2'd1, d); check("single_status", d, 8'h01);
    repeat (5) @(negedge clk);
    check("stale_done", 8'(trmt_cnt), 8'h01);

    // Burst of 9 while a frame is held in flight: 01..08 stored, 09 dropped
    frame_len = 4;
    tx_hold   = 1'b1;
    exp_q.push_back(8'hEE);
    bus_write(2'd0, 8'hEE);
    wait_trmt("burst_first");
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      bus_write(2'd0, 8'(i));
    end
    bus_read(2'd1, d); check("burst_ovf", d, 8'h8E);
    bus_read(2'd1, d); check("burst_ovf_clr", d, 8'h86);
    tx_hold = 1'b0;
    wait_trmt("burst_pop");
    bus_read(2'd1, d); check("burst_count7", d, 8'h74);
    wait_drain("burst_drain");
    bus_read(2'd1, d); check("burst_status", d, 8'h01);

    // Push and pop on the same edge while full
    tx_hold = 1'b1;
    exp_q.push_back(8'h80);
    bus_write(2'd0, 8'h80);
    wait_trmt("pp_first");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h90 + 8'(i));
      bus_write(2'd0, 8'h90 + 8'(i));
    end
    bus_read(2'd1, d); check("pp_full", d, 8'h86);
    tx_hold = 1'b0;
    wait_state(2'd0, "pp_idle");
    tx_hold = 1'b1;
    exp_q.push_back(8'hAA);
    bus_write(2'd0, 8'hAA);
    bus_read(2'd1, d); check("pp_status", d, 8'h86);
    tx_hold = 1'b0;
    wait_drain("pp_drain");
    bus_read(2'd1, d); check("pp_end_status", d, 8'h01);

    // Divisor written mid-frame is held until the frame ends
    tx_hold = 1'b1;
    exp_q.push_back(8'hD1);
    exp_q.push_back(8'hD2);
    bus_write(2'd0, 8'hD1);
    bus_write(2'd0, 8'hD2);
    wait_trmt("div_first");
    repeat (2) @(negedge clk);
    bus_write(2'd2, 8'h10);
    bus_write(2'd3, 8'h00);
    repeat (3) @(negedge clk);
    check("div_busy_dbl", bus.DBL, 8'hB2);
    check("div_busy_dbh", {3'b0, bus.DBH}, 8'h01);
    bus_read(2'd2, d); check("div_pend_dbl", d, 8'h10);
    tx_hold = 1'b0;
    wait_trmt("div_next");
    check("div_new_dbl", bus.DBL, 8'h10);
    check("div_new_dbh", {3'b0, bus.DBH}, 8'h00);
    wait_drain("div_drain");

    // Divisor written while idle: active two cycles later
    bus_write(2'd2, 8'h55);
    check("div_idle_lag", bus.DBL, 8'h10);
    @(negedge clk);
    check("div_idle_dbl", bus.DBL, 8'h55);

    // Asynchronous reset during WAIT with three bytes queued
    tx_hold = 1'b1;
    exp_q.push_back(8'hE1);
    bus_write(2'd0, 8'hE1);
    bus_write(2'd0, 8'hE2);
    bus_write(2'd0, 8'hE3);
    bus_write(2'd0, 8'hE4);
    repeat (3) @(negedge clk);
    bus_read(2'd1, d); check("rst_pre_status", d, 8'h34);
    #2 rst_n = 1'b0;
    #1;
    check("arst_trmt", {7'b0, bus.trmt}, 8'h00);
    check("arst_tx_data", bus.tx_data, 8'h00);
    check("arst_dbl", bus.DBL, 8'hB2);
    check("arst_state", {6'b0, dbg_state}, 8'h00);
    @(negedge clk);
    rst_n   = 1'b1;
    tx_hold = 1'b0;
    @(negedge clk);
    bus_read(2'd1, d); check("arst_status", d, 8'h01);
    rec = trmt_cnt;
    repeat (30) @(negedge clk);
    check("arst_no_trmt", 8'(trmt_cnt - rec), 8'h00);
    check("arst_exp_q", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side controller that sits between the processor bus and the UART transmitter. It buffers outgoing bytes in a small FIFO and sequences them into the transmitter one frame at a time using the transmitter's trmt/tx_done handshake. It also owns the programmable baud divisor (DBL/DBH) and applies divisor updates only between frames.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; legal values 2, 4, 8.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  bus write strobe, one write per cycle
- rd_en  input  1  bus read strobe
- addr  input  2  register select: 0 TXDATA, 1 STATUS, 2 DBL, 3 DBH
- wdata  input  8  bus write data
- rdata  output  8  registered read data, valid the cycle after rd_en
- trmt  output  1  one-cycle start pulse to the transmitter
- tx_data  output  8  byte to transmit; stable while trmt is high and thereafter until the next LOAD
- tx_done  input  1  transmitter done flag; cleared by trmt, set at end of frame, low after reset
- DBL  output  8  active baud divisor, low byte
- DBH  output  5  active baud divisor, high bits

## Operation
- Writes:
  - addr 0 pushes wdata into the FIFO. If the FIFO is full, the byte is dropped and sticky ovf is set.
  - addr 2 writes pending_dbl.
  - addr 3 writes pending_dbh from wdata[4:0].
  - addr 1 writes are ignored.
- Reads (rdata registered):
  - addr 0 returns 8'h00.
  - addr 1 returns STATUS = {count[3:0], ovf, busy, full, empty}. Reading STATUS clears ovf on the same edge. If a drop occurs in that same cycle, set wins.
  - addr 2 returns pending_dbl.
  - addr 3 returns {3'b0, pending_dbh}.
- FIFO behaviour:
  - Circular buffer; pointer width is $clog2(DEPTH) and wraps naturally.
  - count runs 0..DEPTH.
  - A push while full is accepted only if a pop happens in the same cycle; count is then unchanged.
  - A push and pop together on an empty FIFO cannot occur, because a pop requires non-empty.
- Divisor: DBL/DBH are loaded from pending registers on every clock edge where state==IDLE. They never change while a frame is in flight.
- FSM states: IDLE, LOAD, CLR, WAIT.
  - IDLE: if !empty, register the FIFO head into tx_data, pop, and go to LOAD. Otherwise stay.
  - LOAD: trmt=1 for exactly this cycle; go to CLR.
  - CLR: one cycle that lets the transmitter clear tx_done; tx_done is ignored here. Go to WAIT.
  - WAIT: stay while tx_done==0; go to IDLE on tx_done==1.
- busy = (state != IDLE).

## Timing
Reset values:
- state IDLE, FIFO empty, count 0, ovf 0, trmt 0, tx_data 8'h00, rdata 8'h00.
- pending_dbl and DBL 8'hB2; pending_dbh and DBH 5'h01 (divisor 434).

Latency and spacing:
- TXDATA write on cycle N with the FIFO empty and IDLE: count=1 at N+1, trmt high at N+2.
- Back-to-back frames: tx_done sampled high in WAIT at cycle k gives IDLE at k+1 and trmt at k+2. Minimum spacing between trmt pulses is frame time + 3 cycles.
- trmt is never high on two consecutive cycles and never high outside LOAD.
- tx_done==1 in IDLE is ignored; a stale done from a previous frame cannot trigger a frame.

Divisor updates:
- A divisor write while busy takes effect on the first IDLE edge after the frame ends, before the next LOAD.
- A divisor write while IDLE appears on DBL/DBH 2 cycles later (pending 1 cycle, active 1 cycle).

Reset mid-frame: all state returns to reset values immediately, FIFO contents are discarded, and trmt drops asynchronously.

## Test plan
- Reset: check every output at its reset value (DBL=B2, DBH=01, trmt=0). STATUS read returns 8'h01.
- Single byte: write 8'hA5 to addr 0 → trmt pulses 2 cycles later with tx_data=A5 → drive tx_done high after 20 cycles → IDLE, STATUS=8'h01.
- Burst and full: write 9 bytes 01..09 with no transmit progress (hold tx_done low) → count=7 after the first pop, full never exceeded, 9th byte dropped only if full → STATUS ovf=1, then a second STATUS read shows ovf=0. Bytes are emitted in order 01..08.
- Push and pop in the same cycle: with the FIFO full and IDLE, write a byte in the pop cycle → byte accepted, count unchanged at DEPTH.
- Divisor while busy: write DBL=8'h10 and DBH=5'h00 during WAIT → DBL/DBH stay B2/01 until tx_done, then read 10/00 before the next trmt.
- Async reset during WAIT with 3 bytes queued → trmt=0, count=0; no further trmt after release.
